// File: rtl/snake_pkg.sv
// Shared direction/key definitions for the snake input controller.
// One-hot directions, key index map and rotation helpers.
package snake_pkg;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_UP    = 4'b1000;
  localparam dir_t DIR_DOWN  = 4'b0100;
  localparam dir_t DIR_LEFT  = 4'b0010;
  localparam dir_t DIR_RIGHT = 4'b0001;

  localparam int KEY_TURN_L = 0;
  localparam int KEY_TURN_R = 1;
  localparam int KEY_RESET  = 2;
  localparam int KEY_UP     = 3;
  localparam int KEY_DOWN   = 4;
  localparam int KEY_LEFT   = 5;
  localparam int KEY_RIGHT  = 6;

  function automatic dir_t legal_dir(input dir_t d);
    case (d)
      DIR_UP, DIR_DOWN,
      DIR_LEFT, DIR_RIGHT: return d;
      default:             return DIR_RIGHT;
    endcase
  endfunction

  function automatic dir_t rot_left(input dir_t d);
    case (d)
      DIR_UP:   return DIR_LEFT;
      DIR_LEFT: return DIR_DOWN;
      DIR_DOWN: return DIR_RIGHT;
      default:  return DIR_UP;
    endcase
  endfunction

  function automatic dir_t rot_right(input dir_t d);
    case (d)
      DIR_UP:    return DIR_RIGHT;
      DIR_RIGHT: return DIR_DOWN;
      DIR_DOWN:  return DIR_LEFT;
      default:   return DIR_UP;
    endcase
  endfunction

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_input_ctrl_if.sv
// Board/game side bundle of the snake input controller.
// master = keys and game logic, slave = controller.
interface snake_input_ctrl_if
  import snake_pkg::*;
#(
  parameter int NUM_KEYS    = 7,
  parameter int QUEUE_DEPTH = 2
);
  localparam int QCW = $clog2(QUEUE_DEPTH) + 1;

  logic [NUM_KEYS-1:0] key_n;
  logic                abs_mode;
  logic                step;
  dir_t                dir;
  logic                reset;
  logic [NUM_KEYS-1:0] key_state;
  logic                overflow;
  logic [QCW-1:0]      q_count;

  modport master (
    output key_n, abs_mode, step,
    input  dir, reset, key_state,
    input  overflow, q_count
  );

  modport slave (
    input  key_n, abs_mode, step,
    output dir, reset, key_state,
    output overflow, q_count
  );

endinterface

// File: rtl/snake_input_ctrl_debounce.sv
// One debounce channel: 2-flop sync, stability counter,
// debounced level and a press pulse on the falling level.
module key_debounce #(
  parameter int DEB_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // level flips only after DEB_CYCLES disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= ~level;
        press <= level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake key controller: debounced keys, turn/absolute decode,
// direction request FIFO drained one entry per game step.
module snake_input_ctrl
  import snake_pkg::*;
#(
  parameter int NUM_KEYS    = 7,
  parameter int DEB_CYCLES  = 2,
  parameter int CNT_W       = 4,
  parameter int QUEUE_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  snake_input_ctrl_if.slave bus
);

  localparam int AW  = $clog2(QUEUE_DEPTH);
  localparam int QCW = AW + 1;

  logic [NUM_KEYS-1:0] lvl;
  logic [NUM_KEYS-1:0] prs;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .key_n(bus.key_n[g]),
      .level(lvl[g]),
      .press(prs[g])
    );
  end

  logic unused_press;
  assign unused_press = ^prs;

  dir_t           mem [QUEUE_DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [QCW-1:0] cnt;
  dir_t           dir_q;
  logic           rst_p;
  logic           ovf;

  dir_t ref_dir;
  dir_t req_dir;
  logic hit;
  logic req_vld;
  logic full;
  logic push;
  logic pop;

  // pick one request and validate it against the queue tail
  always_comb begin
    ref_dir = legal_dir(dir_q);
    if (cnt != '0) ref_dir = legal_dir(mem[wp - AW'(1)]);
    hit     = 1'b0;
    req_dir = ref_dir;
    if (!bus.abs_mode) begin
      if (prs[KEY_TURN_L]) begin
        hit     = 1'b1;
        req_dir = rot_left(ref_dir);
      end else if (prs[KEY_TURN_R]) begin
        hit     = 1'b1;
        req_dir = rot_right(ref_dir);
      end
    end else begin
      if (prs[KEY_UP]) begin
        hit     = 1'b1;
        req_dir = DIR_UP;
      end else if (prs[KEY_DOWN]) begin
        hit     = 1'b1;
        req_dir = DIR_DOWN;
      end else if (prs[KEY_LEFT]) begin
        hit     = 1'b1;
        req_dir = DIR_LEFT;
      end else if (prs[KEY_RIGHT]) begin
        hit     = 1'b1;
        req_dir = DIR_RIGHT;
      end
    end
    req_vld = hit && (req_dir != ref_dir) &&
              (req_dir != opposite(ref_dir));
    full = (cnt == QCW'(QUEUE_DEPTH));
    push = req_vld && !full;
    pop  = bus.step && (cnt != '0);
  end

  // FIFO, current direction and output pulses; reset key wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= DIR_RIGHT;
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      dir_q <= DIR_RIGHT;
      rst_p <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      rst_p <= prs[KEY_RESET];
      ovf   <= 1'b0;
      if (prs[KEY_RESET]) begin
        wp    <= '0;
        rp    <= '0;
        cnt   <= '0;
        dir_q <= DIR_RIGHT;
      end else begin
        ovf <= req_vld && full;
        if (push) begin
          mem[wp] <= req_dir;
          wp      <= wp + AW'(1);
        end
        if (pop) begin
          dir_q <= legal_dir(mem[rp]);
          rp    <= rp + AW'(1);
        end
        case ({push, pop})
          2'b10:   cnt <= cnt + QCW'(1);
          2'b01:   cnt <= cnt - QCW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign bus.dir       = legal_dir(dir_q);
  assign bus.reset     = rst_p;
  assign bus.key_state = lvl;
  assign bus.overflow  = ovf;
  assign bus.q_count   = cnt;

endmodule
